alu_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the single-cycle integer ALU in the execute stage. Operands enter through a valid/ready handshake. The unit computes over multiple cycles using shift-add multiply and restoring divide, then holds the result until the consumer accepts it. It also produces a Zero flag with the same meaning as the base ALU's flag.

---
 rtl/alu_muldiv.sv | 194 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M/RV64M multiply/divide unit beside the execute-stage ALU.
// Multiply is shift-add and divide is restoring; both work on operand magnitudes,
// and the sign is fixed up on the finalise edge.
// Optional feature macro: ALU_MULDIV_FAST_MUL_EN selects a single-cycle multiplier
// for the four multiply ops. Divide ops stay iterative either way.
//
// state | meaning
// IDLE  | in_ready high, waiting to accept operands
// BUSY  | XLEN iterative steps followed by one finalise edge
// DONE  | result held with out_valid high until out_ready
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            Zero
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic                neg_q;
    // Multiply: acc_q is the product, mcand_q the shifted multiplicand, qreg_q the multiplier.
    // Divide: acc_q[XLEN-1:0] is the partial remainder, mcand_q[XLEN-1:0] the divisor,
    // and qreg_q shifts the dividend out of the top while quotient bits enter at the bottom.
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]     qreg_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     result_q;
    logic                zero_q;

    logic                a_signed, b_signed, sa, sb, neg_in;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                early, b_zero, ovf;
    logic [XLEN-1:0]     early_val;

    // Decode the incoming op: operand signedness, magnitudes, result sign, and early-out cases
    always_comb begin
        a_signed  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_signed  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        sa        = a_signed & a[XLEN-1];
        sb        = b_signed & b[XLEN-1];
        a_mag     = sa ? -a : a;
        b_mag     = sb ? -b : b;
        case (op)
            3'b001:  neg_in = sa ^ sb;
            3'b010:  neg_in = sa;
            3'b100:  neg_in = sa ^ sb;
            3'b110:  neg_in = sa;
            default: neg_in = 1'b0;
        endcase
        b_zero    = (b == '0);
        ovf       = (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1) &&
                    ((op == 3'b100) || (op == 3'b110));
        early     = op[2] && (b_zero || ovf);
        if (b_zero) early_val = op[1] ? a : '1;
        else        early_val = op[1] ? '0 : a;
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;
    logic [XLEN-1:0]   fast_val;

    // Single-cycle product of the sign-extended operands; the low 2*XLEN bits are exact
    always_comb begin
        ext_a     = {{XLEN{sa}}, a};
        ext_b     = {{XLEN{sb}}, b};
        fast_prod = ext_a * ext_b;
        fast_val  = (op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    logic [2*XLEN-1:0] mul_acc_nx, prod;
    logic [XLEN:0]     rem_shift, diff;
    logic              div_ok;
    logic [XLEN-1:0]   quo, remv, fin_val;

    // One iteration step and the finalise-edge sign correction and result selection
    always_comb begin
        mul_acc_nx = qreg_q[0] ? (acc_q + mcand_q) : acc_q;
        rem_shift  = {acc_q[XLEN-1:0], qreg_q[XLEN-1]};
        diff       = rem_shift - {1'b0, mcand_q[XLEN-1:0]};
        div_ok     = ~diff[XLEN];
        prod       = neg_q ? -acc_q : acc_q;
        quo        = neg_q ? -qreg_q : qreg_q;
        remv       = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        case (op_q)
            3'b000:                 fin_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_val = quo;
            default:                fin_val = remv;
        endcase
    end

    // Control FSM and datapath registers; flush overrides every transition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            qreg_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
        end else if (flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q  <= op;
                        neg_q <= neg_in;
                        cnt_q <= '0;
                        if (early) begin
                            result_q    <= early_val;
                            zero_q      <= (early_val == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
`ifdef ALU_MULDIV_FAST_MUL_EN
                        else if (!op[2]) begin
                            result_q    <= fast_val;
                            zero_q      <= (fast_val == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
`endif
                        else begin
                            acc_q <= '0;
                            if (op[2]) begin
                                mcand_q <= {{XLEN{1'b0}}, b_mag};
                                qreg_q  <= a_mag;
                            end else begin
                                mcand_q <= {{XLEN{1'b0}}, a_mag};
                                qreg_q  <= b_mag;
                            end
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CNT_LAST) begin
                        result_q    <= fin_val;
                        zero_q      <= (fin_val == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (op_q[2]) begin
                            acc_q  <= {{XLEN{1'b0}}, div_ok ? diff[XLEN-1:0] : rem_shift[XLEN-1:0]};
                            qreg_q <= {qreg_q[XLEN-2:0], div_ok};
                        end else begin
                            acc_q   <= mul_acc_nx;
                            mcand_q <= mcand_q << 1;
                            qreg_q  <= qreg_q >> 1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: a queue of expected results is filled when each
// operation is issued and drained when out_valid appears.
module tb_alu_muldiv;
    localparam int XLEN = 32;
    localparam int LAT_IT = XLEN + 1;
`ifdef ALU_MULDIV_FAST_MUL_EN
    localparam int LAT_MUL = 1;
`else
    localparam int LAT_MUL = XLEN + 1;
`endif

    logic            clk = 1'b0;
    logic            reset_n, flush, in_valid, in_ready, out_valid, out_ready, Zero;
    logic [XLEN-1:0] a, b, result;
    logic [2:0]      op;

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .Zero(Zero)
    );

    typedef struct {
        string           tag;
        logic [XLEN-1:0] res;
        logic            zero;
        int              lat;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive operands at the falling edge; the next rising edge is the accept edge.
    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] aa, input logic [XLEN-1:0] bb);
        @(negedge clk);
        op = o; a = aa; b = bb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue, wait for out_valid with a bounded budget, then compare against the queue head.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] aa,
                          input logic [XLEN-1:0] bb, input logic [XLEN-1:0] er, input int el);
        exp_t e;
        int   lat;
        e.tag = tag; e.res = er; e.zero = (er == '0); e.lat = el;
        sb_q.push_back(e);
        issue(o, aa, bb);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        e = sb_q.pop_front();
        chk({e.tag, "_lat"},  64'(lat), 64'(e.lat));
        chk({e.tag, "_res"},  64'(result), 64'(e.res));
        chk({e.tag, "_zero"}, 64'(Zero), 64'(e.zero));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_ov"},  64'(out_valid), 64'd0);
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        #12;
        chk("rst_in_ready",  64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result), 64'd0);
        chk("rst_zero",      64'(Zero), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT_MUL);
        release_result("mul");
        run_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, LAT_MUL);
        release_result("mulh");
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, LAT_MUL);
        release_result("mulhsu");
        run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_MUL);
        release_result("mulhu");
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, LAT_IT);
        release_result("divu");
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, LAT_IT);
        release_result("remu");
        run_op("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT_IT);
        release_result("div_neg");
        run_op("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT_IT);
        release_result("rem_neg");

        // Backpressure: hold the REM 6/3 result for 5 cycles
        run_op("rem_zero", 3'b110, 32'd6, 32'd3, 32'd0, LAT_IT);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_ov",  64'(out_valid), 64'd1);
            chk("bp_res", 64'(result), 64'd0);
            chk("bp_z",   64'(Zero), 64'd1);
            chk("bp_rdy", 64'(in_ready), 64'd0);
        end
        release_result("rem_zero");

        run_op("div0", 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        release_result("div0");
        run_op("divu0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        release_result("divu0");
        run_op("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
        release_result("rem0");
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        release_result("div_ovf");
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        release_result("rem_ovf");

        // Flush in IDLE blocks the accept
        @(negedge clk);
        op = 3'b101; a = 32'd9; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_rdy", 64'(in_ready), 64'd1);

        // Flush at BUSY step 10
        issue(3'b101, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_rdy", 64'(in_ready), 64'd1);
        chk("flush_ov",  64'(out_valid), 64'd0);
        watch_no_valid("flush_no_ov", 40);

        // Asynchronous reset at BUSY step 10
        issue(3'b101, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_rdy", 64'(in_ready), 64'd1);
        chk("arst_ov",  64'(out_valid), 64'd0);
        chk("arst_res", 64'(result), 64'd0);
        chk("arst_z",   64'(Zero), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        watch_no_valid("arst_no_ov", 40);

        run_op("divu_after", 3'b101, 32'd9, 32'd3, 32'd3, LAT_IT);
        release_result("divu_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
